// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the datapath's instruction-fetch port and data port
// onto one single-ported backing memory that uses a req/ack handshake.
//
// Ports:
//   clk, reset_n              clock; synchronous active-low reset
//   i_readM/i_address/i_data  instruction read port (i_data is driven continuously)
//   i_ready                   one-cycle pulse when an instruction read completes
//   d_readM/d_writeM/d_address/d_data
//                             data port (d_data is bidirectional)
//   d_ready                   one-cycle pulse when a data access completes
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack
//                             backing-memory handshake
//   timeout_err               sticky; set when a transaction is aborted for lack of ack
//
// Optional: define MEM_ARB_PERF_CNT_EN to add the i_wait_cycles/d_wait_cycles
// saturating wait counters.
module mem_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_readM,
  input  logic [WORD_SIZE-1:0] i_address,
  inout  wire  [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0] d_data,
  output logic                 d_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 timeout_err
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [WORD_SIZE-1:0] i_wait_cycles,
  output logic [WORD_SIZE-1:0] d_wait_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [7:0] LP_TMO = 8'(ACK_TIMEOUT);

  state_t               r_state;
  logic                 r_last_d;   // 1 = last grant went to the data port
  logic [7:0]           r_cnt;
  logic [WORD_SIZE-1:0] r_i_rdata;
  logic [WORD_SIZE-1:0] r_d_rdata;

  logic       w_d_pend;
  logic       w_grant_d;
  logic       w_grant_i;
  logic [7:0] w_cnt_nxt;
  logic       w_tmo;

  assign w_d_pend  = d_readM | d_writeM;
  // Data wins, except an instruction read that already lost once to data.
  assign w_grant_d = w_d_pend & ~(i_readM & r_last_d);
  assign w_grant_i = i_readM & ~w_grant_d;
  assign w_cnt_nxt = r_cnt + 8'd1;
  assign w_tmo     = (w_cnt_nxt >= LP_TMO);

  assign i_data = r_i_rdata;
  // Only drive the data bus for a pure read; a write owns the bus from the datapath side.
  assign d_data = (d_readM && !d_writeM) ? r_d_rdata : {WORD_SIZE{1'bz}};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_cnt       <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_ready     <= 1'b0;
      d_ready     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_grant_d) begin
            mem_addr  <= d_address;
            mem_we    <= d_writeM;  // read+write together counts as a write
            mem_wdata <= d_data;
            mem_req   <= 1'b1;
            r_last_d  <= 1'b1;
            r_state   <= BUSY_D;
          end else if (w_grant_i) begin
            mem_addr <= i_address;
            mem_we   <= 1'b0;
            mem_req  <= 1'b1;
            r_last_d <= 1'b0;
            r_state  <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          r_cnt <= w_cnt_nxt;
          if (mem_ack || w_tmo) begin
            mem_req <= 1'b0;
            r_state <= RESP;
            if (!mem_ack) timeout_err <= 1'b1;
            if (r_state == BUSY_I) begin
              r_i_rdata <= mem_ack ? mem_rdata : '1;
              i_ready   <= 1'b1;
            end else begin
              // A write leaves the last read data untouched.
              if (!mem_we) r_d_rdata <= mem_ack ? mem_rdata : '1;
              d_ready <= 1'b1;
            end
          end
        end
        RESP: begin
          // Requests are deliberately not sampled here so a requester still
          // holding its line for this cycle is not served twice.
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [WORD_SIZE-1:0] r_i_wait;
  logic [WORD_SIZE-1:0] r_d_wait;
  logic                 w_i_served;
  logic                 w_d_served;

  // r_last_d still names the port being answered during RESP.
  assign w_i_served = (r_state == BUSY_I) || (r_state == RESP && !r_last_d);
  assign w_d_served = (r_state == BUSY_D) || (r_state == RESP &&  r_last_d);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_i_wait <= '0;
      r_d_wait <= '0;
    end else begin
      if (i_readM && !w_i_served && r_i_wait != '1) r_i_wait <= r_i_wait + 1'b1;
      if (w_d_pend && !w_d_served && r_d_wait != '1) r_d_wait <= r_d_wait + 1'b1;
    end
  end

  assign i_wait_cycles = r_i_wait;
  assign d_wait_cycles = r_d_wait;
`endif

endmodule
